ps2_receiver: RTL and testbench

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver_if.sv | 12 +
 rtl/ps2_receiver.sv | 166 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_receiver_if.sv
// CPU-side register port of the PS/2 receiver: enable/write/address strobes, write data, read data and irq.
interface ps2_receiver_if;
  logic       en;
  logic       wr;
  logic       addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  modport master (output en, wr, addr, data_in, input data_out, irq);
  modport slave  (input en, wr, addr, data_in, output data_out, irq);
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: sync + falling-edge frame decoder feeding a 4-deep byte FIFO behind a 2-register CPU port.
// Byte visible one cycle after its stop edge; no backpressure -- a push into a full FIFO without a pop is dropped and flagged.
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_receiver_if.slave     bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECEIVE} state_t;

  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
  logic ps2_data_s1_q, ps2_data_s2_q;
  logic ps2_fall;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          push, frame_err_set;

  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic       not_empty, full, pop, push_ok, status_wr;

  logic unused_data_in;
  assign unused_data_in = ^{bus.data_in[7:3], bus.data_in[0]};

  assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    timeout_d     = timeout_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (ps2_fall && !ps2_data_s2_q) begin
          state_d   = RECEIVE;
          bit_cnt_d = 4'd0;
          shift_d   = 8'h00;
          timeout_d = '0;
        end
      end
      RECEIVE: begin
        if (ps2_fall) begin
          timeout_d = '0;
          if (bit_cnt_q < 4'd8) begin
            shift_d   = {ps2_data_s2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd8) begin
            parity_d  = ps2_data_s2_q;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            // Stop bit: odd parity over data+parity bit and a high stop bit.
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            if (ps2_data_s2_q && (^{shift_q, parity_q}))
              push = 1'b1;
            else
              frame_err_set = 1'b1;
          end
        end else if (timeout_q == TO_MAX) begin
          state_d       = IDLE;
          bit_cnt_d     = 4'd0;
          timeout_d     = '0;
          frame_err_set = 1'b1;
        end else begin
          timeout_d = timeout_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign not_empty = (count_q != 3'd0);
  assign full      = (count_q == 3'd4);
  assign pop       = bus.en & ~bus.wr & ~bus.addr & not_empty;
  assign push_ok   = push & (~full | pop);
  assign status_wr = bus.en & bus.wr & bus.addr;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, push_ok} - {2'b00, pop};

    // Clears are applied first so a same-cycle set wins.
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (status_wr && bus.data_in[1]) overflow_d  = 1'b0;
    if (status_wr && bus.data_in[2]) frame_err_d = 1'b0;
    if (push && !push_ok)            overflow_d  = 1'b1;
    if (frame_err_set)               frame_err_d = 1'b1;
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.en && !bus.wr) begin
      if (bus.addr)
        bus.data_out = {5'b00000, frame_err_q, overflow_q, not_empty};
      else if (not_empty)
        bus.data_out = mem_q[rd_ptr_q];
    end
  end

  assign bus.irq = not_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 8'h00;
      parity_q       <= 1'b0;
      timeout_q      <= '0;
      mem_q          <= '{default: 8'h00};
      wr_ptr_q       <= 2'd0;
      rd_ptr_q       <= 2'd0;
      count_q        <= 3'd0;
      overflow_q     <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      ps2_clk_s1_q   <= ps2_clk;
      ps2_clk_s2_q   <= ps2_clk_s1_q;
      ps2_clk_prev_q <= ps2_clk_s2_q;
      ps2_data_s1_q  <= ps2_data;
      ps2_data_s2_q  <= ps2_data_s1_q;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_q       <= parity_d;
      timeout_q      <= timeout_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      frame_err_q    <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: PS/2 frames bit-banged at 8 clk per bit, CPU reads/writes through the interface.
module tb_ps2_receiver;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] rd;
  logic [7:0] rd_stop;

  ps2_receiver_if bus ();

  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    bus.en   = 1'b1;
    bus.wr   = 1'b0;
    bus.addr = a;
    #1 d = bus.data_out;
    wait_cyc(1);
    bus.en = 1'b0;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    bus.en      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    wait_cyc(1);
    bus.en      = 1'b0;
    bus.wr      = 1'b0;
    bus.data_in = 8'h00;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(4);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain; 1: check irq rises exactly one cycle after the stop edge; 2: addr-0 read coinciding with the push
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int mode);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_data = stp;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(2);
    if (mode == 1) begin
      check("irq_before_push", {7'd0, bus.irq}, 8'h00);
      wait_cyc(1);
      check("irq_after_push", {7'd0, bus.irq}, 8'h01);
      wait_cyc(1);
    end else if (mode == 2) begin
      cpu_read(1'b0, rd_stop);
      wait_cyc(1);
    end else begin
      wait_cyc(2);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4);
  endtask

  initial begin
    reset       = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    bus.en      = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = 1'b0;
    bus.data_in = 8'h00;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(1);

    check("reset_irq", {7'd0, bus.irq}, 8'h00);
    check("reset_dout_en0", bus.data_out, 8'h00);
    cpu_read(1'b1, rd); check("reset_status", rd, 8'h00);

    // Single good frame
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    check("en0_dout_nonempty", bus.data_out, 8'h00);
    cpu_read(1'b1, rd); check("f1_status", rd, 8'h01);
    cpu_read(1'b0, rd); check("f1_data", rd, 8'h1C);
    cpu_read(1'b1, rd); check("f1_status_after", rd, 8'h00);
    check("f1_irq_after", {7'd0, bus.irq}, 8'h00);

    // Two frames in order, then empty read
    send_frame(8'hF0, 1'b1, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    cpu_read(1'b0, rd); check("ord_first", rd, 8'hF0);
    cpu_read(1'b0, rd); check("ord_second", rd, 8'h1C);
    cpu_read(1'b0, rd); check("ord_empty", rd, 8'h00);
    cpu_read(1'b1, rd); check("ord_empty_status", rd, 8'h00);

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    cpu_read(1'b1, rd); check("par_err_status", rd, 8'h04);
    check("par_err_irq", {7'd0, bus.irq}, 8'h00);
    cpu_write(1'b1, 8'h04);
    cpu_read(1'b1, rd); check("par_err_cleared", rd, 8'h00);

    // Bad stop bit
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    cpu_read(1'b1, rd); check("stop_err_status", rd, 8'h04);
    cpu_write(1'b1, 8'h04);

    // Overflow with five frames
    send_frame(8'h11, 1'b1, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    send_frame(8'h33, 1'b1, 1'b1, 0);
    send_frame(8'h44, 1'b1, 1'b1, 0);
    send_frame(8'h55, 1'b1, 1'b1, 0);
    cpu_read(1'b1, rd); check("ovf_status", rd, 8'h03);
    cpu_write(1'b0, 8'hFF);
    cpu_read(1'b1, rd); check("wr_addr0_ignored", rd, 8'h03);
    cpu_read(1'b0, rd); check("ovf_rd0", rd, 8'h11);
    cpu_read(1'b0, rd); check("ovf_rd1", rd, 8'h22);
    cpu_read(1'b0, rd); check("ovf_rd2", rd, 8'h33);
    cpu_read(1'b0, rd); check("ovf_rd3", rd, 8'h44);
    cpu_read(1'b0, rd); check("ovf_rd_empty", rd, 8'h00);
    cpu_read(1'b1, rd); check("ovf_sticky", rd, 8'h02);
    cpu_write(1'b1, 8'h02);
    cpu_read(1'b1, rd); check("ovf_cleared", rd, 8'h00);

    // Timeout on a partial frame, then recovery
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(TO + 20);
    cpu_read(1'b1, rd); check("timeout_status", rd, 8'h04);
    cpu_write(1'b1, 8'h04);
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    cpu_read(1'b1, rd); check("post_to_status", rd, 8'h01);
    cpu_read(1'b0, rd); check("post_to_data", rd, 8'h5A);

    // Full FIFO with a pop on the stop-bit edge
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h02, 1'b0, 1'b1, 0);
    send_frame(8'h03, 1'b1, 1'b1, 0);
    send_frame(8'h04, 1'b0, 1'b1, 0);
    send_frame(8'h77, 1'b1, 1'b1, 2);
    check("full_pop_head", rd_stop, 8'h01);
    cpu_read(1'b1, rd); check("full_pop_status", rd, 8'h01);
    cpu_read(1'b0, rd); check("full_pop_rd0", rd, 8'h02);
    cpu_read(1'b0, rd); check("full_pop_rd1", rd, 8'h03);
    cpu_read(1'b0, rd); check("full_pop_rd2", rd, 8'h04);
    cpu_read(1'b0, rd); check("full_pop_rd3", rd, 8'h77);
    cpu_read(1'b0, rd); check("full_pop_empty", rd, 8'h00);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(2);
    cpu_read(1'b1, rd); check("midrst_status", rd, 8'h00);
    check("midrst_irq", {7'd0, bus.irq}, 8'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    cpu_read(1'b0, rd); check("midrst_next_frame", rd, 8'h1C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
